// File: rtl/fir_mac_sched_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC scheduler.
package fir_mac_sched_pkg;

  typedef enum logic [2:0] {CLR, IDLE, ISSUE, WAIT, OUT} state_t;

  localparam int CH_NUM_DFLT  = 4;
  localparam int TAP_NUM_DFLT = 8;

  // A 1-entry space still needs a 1-bit address so port widths never collapse to zero.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_AW  = addr_w(CH_NUM_DFLT);
  localparam int TAP_AW = addr_w(TAP_NUM_DFLT);

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Sample history store: one write port, one combinational read port, addressed {ch,idx}.
module fir_hist_ram
  import fir_mac_sched_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_sched.sv
// FIR controller sharing one external pipelined MAC across CH_NUM channels.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_sched
  import fir_mac_sched_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DFLT,
  parameter int TAP_NUM   = TAP_NUM_DFLT,
  parameter int DATA_WDTH = 16,
  parameter int COEF_WDTH = 16,
  parameter int ACC_WDTH  = 40,
  parameter int MAC_DELAY = 2,
  parameter int OUT_WDTH  = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [addr_w(CH_NUM)-1:0]    s_ch,
  input  logic [DATA_WDTH-1:0]         s_data,
  input  logic                         cfg_we,
  input  logic [addr_w(TAP_NUM)-1:0]   cfg_addr,
  input  logic [COEF_WDTH-1:0]         cfg_data,
  output logic                         cfg_busy,
  output logic [DATA_WDTH-1:0]         mac_a,
  output logic [COEF_WDTH-1:0]         mac_b,
  output logic [ACC_WDTH-1:0]          mac_c,
  input  logic [ACC_WDTH-1:0]          mac_sum,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [addr_w(CH_NUM)-1:0]    m_ch,
  output logic [OUT_WDTH-1:0]          m_data
);

  localparam int CAW   = addr_w(CH_NUM);
  localparam int TAW   = addr_w(TAP_NUM);
  localparam int AW    = CAW + TAW;
  localparam int DEPTH = CH_NUM * TAP_NUM;
  localparam logic [AW-1:0]  CLR_LAST = AW'(DEPTH - 1);
  localparam logic [TAW-1:0] K_LAST   = TAW'(TAP_NUM - 1);

  state_t                            state, state_nxt;
  logic [AW-1:0]                     clr_cnt;
  logic [TAW-1:0]                    k;
  logic [CAW-1:0]                    ch;
  logic [ACC_WDTH-1:0]               acc;
  logic [MAC_DELAY:0]                vld_pipe;
  logic [TAP_NUM-1:0][COEF_WDTH-1:0] coef;
  logic [CH_NUM-1:0][TAW-1:0]        wptr;

  logic                 accept, sum_rdy, res_done;
  logic                 ram_we;
  logic [AW-1:0]        ram_waddr, ram_raddr;
  logic [DATA_WDTH-1:0] ram_wdata, ram_rdata;
  logic [TAW-1:0]       rd_idx;

  assign s_ready  = (state == IDLE);
  assign cfg_busy = (state != IDLE);
  assign accept   = s_valid & s_ready;
  // vld_pipe[MAC_DELAY] marks the cycle the MAC result for the current tap appears.
  assign sum_rdy  = (state == WAIT) & vld_pipe[MAC_DELAY];
  assign m_valid  = (state == OUT);
  assign res_done = m_valid & m_ready;
  assign m_ch     = ch;

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR:     if (clr_cnt == CLR_LAST) state_nxt = IDLE;
      IDLE:    if (s_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (sum_rdy) state_nxt = (k == K_LAST) ? OUT : ISSUE;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLR;
      clr_cnt  <= '0;
      k        <= '0;
      ch       <= '0;
      acc      <= '0;
      vld_pipe <= '0;
      coef     <= '0;
      wptr     <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[MAC_DELAY-1:0], state_nxt == ISSUE};
      if (state == CLR) clr_cnt <= clr_cnt + AW'(1);
      if ((state == IDLE) && cfg_we) coef[cfg_addr] <= cfg_data;
      if (accept) begin
        ch <= s_ch;
        k  <= '0;
      end
      if (sum_rdy) begin
        acc <= mac_sum;
        if (k != K_LAST) k <= k + TAW'(1);
      end
      if (res_done) wptr[ch] <= wptr[ch] + TAW'(1);
    end
  end

  // Newest sample sits at wptr; tap k reaches k samples back, wrapping modulo TAP_NUM.
  assign rd_idx    = wptr[ch] - k;
  assign ram_raddr = {ch, rd_idx};
  assign ram_we    = (state == CLR) | accept;
  assign ram_waddr = (state == CLR) ? clr_cnt : {s_ch, wptr[s_ch]};
  assign ram_wdata = (state == CLR) ? '0 : s_data;

  fir_hist_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_WDTH)
  ) u_hist (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    if ((state == ISSUE) || (state == WAIT)) begin
      mac_a = ram_rdata;
      mac_b = coef[k];
      mac_c = (k == '0) ? '0 : acc;
    end
  end

`ifdef FIR_MAC_SAT_EN
  assign m_data = OUT_WDTH'(saturate(64'($signed(acc) >>> OUT_SHIFT), OUT_WDTH));
`else
  assign m_data = OUT_WDTH'($signed(acc) >>> OUT_SHIFT);
`endif

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched with a behavioural pipelined MAC and a tap-history reference model.
module tb_fir_mac_sched;

  localparam int CH  = 2;
  localparam int TAP = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int AW  = 40;
  localparam int MD  = 2;
  localparam int OW  = 16;
  localparam int SH  = 0;
  localparam int LAT = 1 + TAP * (MD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [0:0]    s_ch = '0;
  logic [DW-1:0] s_data = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_busy;
  logic [DW-1:0] mac_a;
  logic [CW-1:0] mac_b;
  logic [AW-1:0] mac_c;
  logic [AW-1:0] mac_sum;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [0:0]    m_ch;
  logic [OW-1:0] m_data;

  always #5 clk = ~clk;

  fir_mac_sched #(
    .CH_NUM(CH), .TAP_NUM(TAP), .DATA_WDTH(DW), .COEF_WDTH(CW),
    .ACC_WDTH(AW), .MAC_DELAY(MD), .OUT_WDTH(OW), .OUT_SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_sum(mac_sum),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch), .m_data(m_data)
  );

  // External MAC: sum = a*b + c, MD cycles later.
  logic [AW-1:0] mac_pipe [MD];
  always @(posedge clk) begin
    mac_pipe[0] <= AW'(longint'($signed(mac_a)) * longint'($signed(mac_b)) + longint'($signed(mac_c)));
    for (int i = 1; i < MD; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_sum = mac_pipe[MD-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: coefficient table and newest-first sample window per channel.
  longint coef_m [TAP];
  longint hist_m [CH][TAP];

  function automatic void model_reset();
    for (int t = 0; t < TAP; t++) begin
      coef_m[t] = 0;
      for (int c = 0; c < CH; c++) hist_m[c][t] = 0;
    end
  endfunction

  function automatic longint model_fmt(input longint sum);
    longint s;
    s = sum >>> SH;
`ifdef FIR_MAC_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s & 64'hFFFF;
  endfunction

  function automatic longint model_push(input int c, input int d);
    logic signed [DW-1:0] d16;
    longint sum;
    d16 = DW'(d);
    for (int i = TAP - 1; i > 0; i--) hist_m[c][i] = hist_m[c][i-1];
    hist_m[c][0] = longint'(d16);
    sum = 0;
    for (int i = 0; i < TAP; i++) sum += coef_m[i] * hist_m[c][i];
    return model_fmt(sum);
  endfunction

  task automatic set_coef(input int t, input int v);
    logic signed [CW-1:0] v16;
    v16 = CW'(v);
    chk("cfg_busy_idle", cfg_busy, 0);
    cfg_we = 1'b1; cfg_addr = 2'(t); cfg_data = v16;
    @(negedge clk);
    cfg_we = 1'b0;
    coef_m[t] = longint'(v16);
  endtask

  task automatic reset_pulse(input string tag);
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_ch"}, m_ch, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_cfg_busy"}, cfg_busy, 1);
    chk({tag, "_mac_abc"}, {mac_a, mac_b, mac_c} == '0, 1);
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_clr_cycles"}, n, CH * TAP);
    model_reset();
  endtask

  task automatic run_sample(input int c, input int d, input int stall, input bit poke,
                            input longint exp, input string tag, output int lat);
    int n;
    s_valid = 1'b1; s_ch = 1'(c); s_data = DW'(d); m_ready = (stall == 0);
    n = 0;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk({tag, "_accept_timeout"}, s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; cfg_we = 1'b0;
    lat = 1;
    while (!m_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    if (!m_valid) chk({tag, "_result_timeout"}, m_valid, 1);
    chk({tag, "_data"}, m_data, exp);
    chk({tag, "_ch"}, m_ch, c);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 5) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'd99;
      end
      @(negedge clk);
      if (poke && i == 5) begin
        chk({tag, "_cfg_busy"}, cfg_busy, 1);
        cfg_we = 1'b0;
      end
      chk({tag, "_hold_valid"}, m_valid, 1);
      chk({tag, "_hold_data"}, m_data, exp);
      chk({tag, "_hold_sready"}, s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_sready_after"}, s_ready, 1);
  endtask

  typedef struct {
    int     ch;
    int     data;
    longint exp;
  } vec_t;

  vec_t   tbl [7];
  int     lat;
  longint e;

  initial begin
    tbl[0] = '{0, 1, 1};
    tbl[1] = '{0, 0, 2};
    tbl[2] = '{0, 0, 3};
    tbl[3] = '{0, 0, 4};
    tbl[4] = '{0, 10, 10};
    tbl[5] = '{1, 5, 5};
    tbl[6] = '{0, 20, 40};

    model_reset();
    repeat (2) @(negedge clk);
    reset_pulse("init");

    set_coef(0, 1);
    e = model_push(0, 100);
    run_sample(0, 100, 0, 0, 100, "first", lat);

    // Impulse response and channel isolation from cleared history.
    reset_pulse("r2");
    for (int t = 0; t < TAP; t++) set_coef(t, t + 1);
    for (int i = 0; i < 7; i++) begin
      e = model_push(tbl[i].ch, tbl[i].data);
      run_sample(tbl[i].ch, tbl[i].data, 0, 0, tbl[i].exp, $sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure with a dropped cfg write, then readback with the old coefficients.
    e = model_push(1, 3);
    run_sample(1, 3, 20, 1, 13, "bp", lat);
    e = model_push(1, 1);
    run_sample(1, 1, 0, 0, e, "bp_readback", lat);
    chk("bp_readback_const", m_data, 22);

    // Coefficient write in the accept cycle is seen by that sample.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'd2;
    coef_m[0] = 2;
    e = model_push(0, 7);
    run_sample(0, 7, 0, 0, e, "cfg_same_cycle", lat);

    for (int i = 0; i < 30; i++) begin
      int c, d, st;
      if ($urandom_range(0, 3) == 0)
        set_coef($urandom_range(0, TAP - 1), int'($urandom_range(0, 600)) - 300);
      c  = $urandom_range(0, CH - 1);
      d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 200)) - 100;
      st = $urandom_range(0, 3);
      e  = model_push(c, d);
      run_sample(c, d, st, 0, e, $sformatf("rnd%0d", i), lat);
    end

    // Full-scale accumulation: clamps when saturating, wraps otherwise.
    reset_pulse("sat");
    for (int t = 0; t < TAP; t++) set_coef(t, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin
      e = model_push(0, 16'h7FFF);
      run_sample(0, 16'h7FFF, 0, 0, e, $sformatf("sat%0d", i), lat);
    end
    e = model_push(0, 16'h7FFF);
`ifdef FIR_MAC_SAT_EN
    run_sample(0, 16'h7FFF, 0, 0, 64'h7FFF, "sat_full", lat);
`else
    run_sample(0, 16'h7FFF, 0, 0, 64'h0004, "sat_full", lat);
`endif
    for (int i = 0; i < 4; i++) begin
      e = model_push(0, -32768);
      run_sample(0, -32768, 0, 0, e, $sformatf("satneg%0d", i), lat);
    end

    // Reset during the WAIT of tap 2.
    for (int t = 0; t < TAP; t++) set_coef(t, t + 1);
    s_valid = 1'b1; s_ch = 1'b0; s_data = 16'd50;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("midop_mac_b", mac_b, 3);
    chk("midop_m_valid", m_valid, 0);
    reset_pulse("midop");
    for (int t = 0; t < TAP; t++) set_coef(t, t + 1);
    e = model_push(0, 9);
    run_sample(0, 9, 0, 0, 9, "post_rst_ch0", lat);
    e = model_push(1, 11);
    run_sample(1, 11, 0, 0, 11, "post_rst_ch1", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
Time-multiplexed FIR controller that shares one external myip_mac-style multiply-accumulate unit across CH_NUM channels.
- Accepts one sample per handshake and writes it into a per-channel circular history.
- Sequences TAP_NUM MAC operations through the pipelined MAC, feeding the running sum back through the MAC's c input.
- Returns one filtered result per sample.
- Sits between the ADC channel mux and downstream FIR post-processing.

Parameters:
CH_NUM, 4, number of channels sharing the MAC (power of two, ≥1)
TAP_NUM, 8, filter taps (power of two, ≥2)
DATA_WDTH, 16, signed sample width (MAC a)
COEF_WDTH, 16, signed coefficient width (MAC b)
ACC_WDTH, 40, accumulator width (MAC c and sum); must be ≥ DATA_WDTH+COEF_WDTH+log2(TAP_NUM)
MAC_DELAY, 2, MAC pipeline depth in cycles; must be ≥1
OUT_WDTH, 16, output width
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before output

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  sample valid
s_ready  out  1  sample accept
s_ch  in  log2(CH_NUM)  sample channel
s_data  in  DATA_WDTH  signed sample
cfg_we  in  1  coefficient write strobe
cfg_addr  in  log2(TAP_NUM)  tap index
cfg_data  in  COEF_WDTH  signed coefficient
cfg_busy  out  1  high when cfg writes are being dropped
mac_a  out  DATA_WDTH  to MAC a
mac_b  out  COEF_WDTH  to MAC b
mac_c  out  ACC_WDTH  to MAC c
mac_sum  in  ACC_WDTH  from MAC sum, MAC_DELAY cycles after a/b/c
m_valid  out  1  result valid
m_ready  in  1  result accept
m_ch  out  log2(CH_NUM)  result channel
m_data  out  OUT_WDTH  result

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: s_ready=0, cfg_busy=1, m_valid=0, m_ch=0, m_data=0, mac_a/b/c=0. All coefficients=0, all write pointers=0. The FSM enters CLR.
- CLR: zeroes the history RAM (CH_NUM*TAP_NUM entries), one entry per cycle, then goes to IDLE.
  - rst asserted in any state, including mid-filter, restarts CLR.
  - Any in-flight MAC result is ignored.
- IDLE: s_ready=1, cfg_busy=0.
  - cfg_we writes coef[cfg_addr] in IDLE only; in other states writes are dropped and cfg_busy=1.
  - On s_valid&s_ready in cycle T: hist[s_ch][wptr[s_ch]] <= s_data; latch ch; tap counter k=0; go to ISSUE.
  - A cfg write and a sample accept in the same cycle: the write completes first and is used by this sample.
- ISSUE (1 cycle): drive mac_a=hist[ch][(wptr-k) mod TAP_NUM], mac_b=coef[k], mac_c=(k==0)?0:acc. Go to WAIT.
- WAIT (MAC_DELAY cycles): mac_a/b/c held.
  - On the last WAIT cycle: acc <= mac_sum.
  - If k==TAP_NUM-1, go to OUT; else k++ and go to ISSUE.
  - Tap period P = MAC_DELAY+1.
- OUT: m_valid=1 starting in cycle T+1+TAP_NUM*P; wptr[ch] increments (wraps at TAP_NUM).
  - m_data, m_ch and m_valid are held stable until m_ready.
  - On m_valid&m_ready: go to IDLE. s_ready rises the following cycle.
  - Throughput: one sample per TAP_NUM*P+2 cycles, minimum.
- Arithmetic:
  - Samples and coefficients are two's complement.
  - Accumulation is done only in the MAC; the controller does not add.
  - Out-of-range s_ch is not possible because CH_NUM is a power of two.
- MAC idle drive: outside ISSUE/WAIT, mac_a/b/c=0.

Optional Feature:
FIR_MAC_SAT_EN:
- Defined: m_data = saturate(acc >>> OUT_SHIFT) to the signed OUT_WDTH range, clamping at the min/max values.
- Undefined: m_data = the low OUT_WDTH bits of acc >>> OUT_SHIFT (wraps).

Decomposition:
- Package fir_mac_sched_pkg holds:
  - FSM state enum: CLR, IDLE, ISSUE, WAIT, OUT
  - width-derived localparams: CH_AW, TAP_AW
  - saturate function
- Sub-module fir_hist_ram: CH_NUM*TAP_NUM x DATA_WDTH register RAM, one write port, one combinational read port, addressed {ch,idx}.
- Coefficients are a flat register array inside the top level.
- Testbench pairs the block with the existing myip_mac instance, BUS_DELAY=MAC_DELAY.

Test Plan:
- Reset/clear: rst for 1 cycle → s_ready low for exactly CH_NUM*TAP_NUM cycles, then high. First sample 100 on ch0 with coef0=1 (others 0) → m_data=100.
- Impulse response: CH_NUM=2, TAP_NUM=4, MAC_DELAY=2, OUT_SHIFT=0, coefs 1,2,3,4. ch0 samples 1,0,0,0 → outputs 1,2,3,4. m_valid rises exactly 13 cycles after the accept cycle.
- Channel isolation: ch0 samples 10,20 interleaved with ch1 sample 5 (coefs 1,2,3,4) → ch0 outputs 10 and 40, ch1 output 5. m_ch is correct on each.
- Backpressure: hold m_ready=0 for 20 cycles → m_valid/m_data stable, s_ready=0, no wptr advance. A cfg_we during this window is dropped (readback via later impulse shows old coefs).
- Saturation: coefs 0x7FFF x4, samples 0x7FFF, OUT_SHIFT=15. With FIR_MAC_SAT_EN → 0x7FFF; without → the wrapped low 16 bits.
- Mid-op reset: assert rst during WAIT of tap 2 → m_valid=0 next cycle, CLR re-runs, and the next result is computed from cleared history.
